// File: rtl/elevador_pkg.sv
// Shared constants, FSM encoding and helpers for the elevator request scheduler.
package elevador_pkg;

    localparam int N_PISOS = 4;
    localparam int W_PISO  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SUBIR  = 2'd1,
        BAJAR  = 2'd2,
        PARADA = 2'd3
    } estado_t;

    localparam logic DIR_SUBIR = 1'b1;
    localparam logic DIR_BAJAR = 1'b0;

    function automatic logic [N_PISOS-1:0] onehot_piso(input logic [W_PISO-1:0] piso);
        logic [N_PISOS-1:0] uno;
        uno = {{(N_PISOS-1){1'b0}}, 1'b1};
        return uno << piso;
    endfunction

endpackage

// File: rtl/planificador_elevador_if.sv
// Button/sensor inputs and motion/door commands of the elevator scheduler.
interface planificador_elevador_if;
    import elevador_pkg::*;

    logic [N_PISOS-1:0] peticion;
    logic [N_PISOS-1:0] seleccion;
    logic [W_PISO-1:0]  piso_actual;
    logic               en_piso;
    logic               servido;
    logic               emergencia;

    logic [N_PISOS-1:0] pendientes;
    logic               mover;
    logic               direccion;
    logic               abrir_puerta;
    logic [W_PISO-1:0]  objetivo;
    logic               objetivo_valido;

    modport master (
        output peticion, seleccion, piso_actual, en_piso, servido, emergencia,
        input  pendientes, mover, direccion, abrir_puerta, objetivo, objetivo_valido
    );

    modport slave (
        input  peticion, seleccion, piso_actual, en_piso, servido, emergencia,
        output pendientes, mover, direccion, abrir_puerta, objetivo, objetivo_valido
    );

endinterface

// File: rtl/planificador_elevador_buscar_piso.sv
// Nearest pending floor strictly above and strictly below a reference floor.
module buscar_piso
    import elevador_pkg::*;
(
    input  logic [N_PISOS-1:0] pend,
    input  logic [W_PISO-1:0]  piso,
    output logic               arriba,
    output logic               abajo,
    output logic [W_PISO-1:0]  piso_arriba,
    output logic [W_PISO-1:0]  piso_abajo
);

    logic [N_PISOS-1:0] sobre;
    logic [N_PISOS-1:0] bajo;

    genvar gi;
    generate
        for (gi = 0; gi < N_PISOS; gi++) begin : g_mascara
            assign sobre[gi] = pend[gi] & (gi > int'(piso));
            assign bajo[gi]  = pend[gi] & (gi < int'(piso));
        end
    endgenerate

    assign arriba = |sobre;
    assign abajo  = |bajo;

    // Above: lowest set bit wins; below: highest set bit wins. Zero when none.
    always_comb begin
        piso_arriba = '0;
        for (int i = N_PISOS - 1; i >= 0; i--) begin
            if (sobre[i]) piso_arriba = W_PISO'(i);
        end
        piso_abajo = '0;
        for (int i = 0; i < N_PISOS; i++) begin
            if (bajo[i]) piso_abajo = W_PISO'(i);
        end
    end

endmodule

// File: rtl/planificador_elevador.sv
// Collective-SCAN scheduler: latches hall/cab calls and drives motor, direction and door requests.
module planificador_elevador
    import elevador_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    planificador_elevador_if.slave bus
);

    logic [N_PISOS-1:0] pend_reg, pend_next, clr;
    estado_t            estado_reg, estado_next;
    logic               dir_reg, dir_next;

    logic [N_PISOS-1:0] busq_pend;
    logic               arriba, abajo, aqui;
    logic [W_PISO-1:0]  piso_arriba, piso_abajo;

    logic               mover, abrir_puerta, objetivo_valido;
    logic [W_PISO-1:0]  objetivo;

    // A new call on the floor being cleared survives, so that floor is served again later.
    assign clr       = bus.servido ? onehot_piso(bus.piso_actual) : '0;
    assign pend_next = (pend_reg & ~clr) | bus.peticion | bus.seleccion;

    // The departure decision at a stop must already see the floor just served as cleared.
    assign busq_pend = (estado_reg == PARADA) ? pend_next : pend_reg;
    assign aqui      = pend_reg[bus.piso_actual] & bus.en_piso;

    buscar_piso u_buscar (
        .pend        (busq_pend),
        .piso        (bus.piso_actual),
        .arriba      (arriba),
        .abajo       (abajo),
        .piso_arriba (piso_arriba),
        .piso_abajo  (piso_abajo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_reg   <= '0;
            estado_reg <= IDLE;
            dir_reg    <= DIR_SUBIR;
        end else begin
            pend_reg   <= pend_next;
            estado_reg <= estado_next;
            dir_reg    <= dir_next;
        end
    end

    always_comb begin
        estado_next = estado_reg;
        dir_next    = dir_reg;
        if (!bus.emergencia) begin
            unique case (estado_reg)
                IDLE: begin
                    if (aqui) begin
                        estado_next = PARADA;
                    end else if (arriba) begin
                        estado_next = SUBIR;
                        dir_next    = DIR_SUBIR;
                    end else if (abajo) begin
                        estado_next = BAJAR;
                        dir_next    = DIR_BAJAR;
                    end
                end
                SUBIR, BAJAR: begin
                    if (aqui) estado_next = PARADA;
                end
                PARADA: begin
                    if (bus.servido) begin
                        if (dir_reg == DIR_SUBIR) begin
                            if (arriba) begin
                                estado_next = SUBIR;
                            end else if (abajo) begin
                                estado_next = BAJAR;
                                dir_next    = DIR_BAJAR;
                            end else begin
                                estado_next = IDLE;
                            end
                        end else begin
                            if (abajo) begin
                                estado_next = BAJAR;
                            end else if (arriba) begin
                                estado_next = SUBIR;
                                dir_next    = DIR_SUBIR;
                            end else begin
                                estado_next = IDLE;
                            end
                        end
                    end
                end
                default: estado_next = IDLE;
            endcase
        end
    end

    always_comb begin
        mover           = 1'b0;
        abrir_puerta    = 1'b0;
        objetivo        = '0;
        objetivo_valido = 1'b0;
        unique case (estado_reg)
            SUBIR: begin
                mover           = ~bus.emergencia;
                objetivo        = piso_arriba;
                objetivo_valido = 1'b1;
            end
            BAJAR: begin
                mover           = ~bus.emergencia;
                objetivo        = piso_abajo;
                objetivo_valido = 1'b1;
            end
            PARADA: begin
                abrir_puerta    = 1'b1;
                objetivo        = bus.piso_actual;
                objetivo_valido = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.pendientes      = pend_reg;
    assign bus.mover           = mover;
    assign bus.direccion       = dir_reg;
    assign bus.abrir_puerta    = abrir_puerta;
    assign bus.objetivo        = objetivo;
    assign bus.objetivo_valido = objetivo_valido;

endmodule

// File: tb/tb_planificador_elevador.sv
// Directed scenarios followed by random traffic, checked cycle by cycle against a behavioural model.
module tb_planificador_elevador;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    planificador_elevador_if bus ();

    planificador_elevador dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model: pending calls as a plain bit set, motion as a mode number.
    localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_STOP = 3;
    bit [3:0] m_pend = 4'b0;
    int       m_mode = M_IDLE;
    bit       m_up   = 1'b1;

    function automatic int nearest_above(bit [3:0] p, int f);
        for (int i = f + 1; i < 4; i++) if (p[i]) return i;
        return -1;
    endfunction

    function automatic int nearest_below(bit [3:0] p, int f);
        for (int i = f - 1; i >= 0; i--) if (p[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d at t=%0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_edge(input bit [3:0] pet, input bit [3:0] sel, input int piso,
                              input bit en, input bit srv, input bit emg, input bit r);
        bit [3:0] newp, view;
        bit       here, go_up, go_dn;
        if (r) begin
            m_pend = 4'b0; m_mode = M_IDLE; m_up = 1'b1;
            return;
        end
        newp = m_pend;
        if (srv) newp[piso] = 1'b0;
        newp = newp | pet | sel;
        if (!emg) begin
            view  = (m_mode == M_STOP) ? newp : m_pend;
            go_up = nearest_above(view, piso) >= 0;
            go_dn = nearest_below(view, piso) >= 0;
            here  = m_pend[piso] && en;
            case (m_mode)
                M_IDLE: begin
                    if (here) m_mode = M_STOP;
                    else if (go_up) begin m_mode = M_UP; m_up = 1'b1; end
                    else if (go_dn) begin m_mode = M_DOWN; m_up = 1'b0; end
                end
                M_UP, M_DOWN: if (here) m_mode = M_STOP;
                default: if (srv) begin
                    if (m_up ? go_up : go_dn) m_mode = m_up ? M_UP : M_DOWN;
                    else if (m_up ? go_dn : go_up) begin
                        m_up   = !m_up;
                        m_mode = m_up ? M_UP : M_DOWN;
                    end else m_mode = M_IDLE;
                end
            endcase
        end
        m_pend = newp;
    endtask

    task automatic check_outputs(input int piso, input bit emg);
        int obj;
        obj = 0;
        if (m_mode == M_UP)   obj = nearest_above(m_pend, piso);
        if (m_mode == M_DOWN) obj = nearest_below(m_pend, piso);
        if (m_mode == M_STOP) obj = piso;
        if (obj < 0) obj = 0;
        chk("pendientes", 8'(bus.pendientes), 8'(m_pend));
        chk("mover", 8'(bus.mover), 8'((m_mode == M_UP || m_mode == M_DOWN) && !emg));
        chk("direccion", 8'(bus.direccion), 8'(m_up));
        chk("abrir_puerta", 8'(bus.abrir_puerta), 8'(m_mode == M_STOP));
        chk("objetivo_valido", 8'(bus.objetivo_valido), 8'(m_mode != M_IDLE));
        chk("objetivo", 8'(bus.objetivo), 8'(obj));
    endtask

    // One clock cycle with the given inputs held across the active edge.
    task automatic step(input bit [3:0] pet, input bit [3:0] sel, input int piso,
                        input bit en, input bit srv, input bit emg, input bit r);
        bus.peticion    = pet;
        bus.seleccion   = sel;
        bus.piso_actual = 2'(piso);
        bus.en_piso     = en;
        bus.servido     = srv;
        bus.emergencia  = emg;
        rst             = r;
        @(posedge clk);
        model_edge(pet, sel, piso, en, srv, emg, r);
        #1;
        check_outputs(piso, emg);
    endtask

    task automatic wait_at(input int piso, input bit en, input int n);
        for (int i = 0; i < n; i++) step(4'b0, 4'b0, piso, en, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int piso_r;
        bit [3:0] pet_r, sel_r;
        bit en_r, srv_r, emg_r, rst_r;

        // Reset values
        step(4'b0, 4'b0, 0, 1, 0, 0, 1);
        step(4'b0, 4'b0, 0, 1, 0, 0, 1);

        // Call on the current floor: stop without moving, then clear
        step(4'b0001, 4'b0, 0, 1, 0, 0, 0);
        wait_at(0, 1, 2);
        step(4'b0, 4'b0, 0, 1, 1, 0, 0);
        wait_at(0, 1, 1);

        // Cab call to top floor from floor 0
        step(4'b0, 4'b1000, 0, 1, 0, 0, 0);
        wait_at(0, 1, 1);
        wait_at(1, 0, 1);
        wait_at(1, 1, 1);
        wait_at(2, 0, 1);
        wait_at(3, 1, 2);
        step(4'b0, 4'b0, 3, 1, 1, 0, 0);

        // Back to floor 0
        step(4'b0, 4'b0001, 3, 1, 0, 0, 0);
        wait_at(3, 1, 1);
        wait_at(2, 0, 1);
        wait_at(1, 0, 1);
        wait_at(0, 1, 1);
        step(4'b0, 4'b0, 0, 1, 1, 0, 0);

        // Intermediate stop on the way up, then resume upward
        step(4'b0, 4'b1010, 0, 1, 0, 0, 0);
        wait_at(0, 1, 1);
        wait_at(1, 1, 2);
        step(4'b0, 4'b0, 1, 1, 1, 0, 0);
        wait_at(2, 0, 1);
        wait_at(3, 1, 1);
        step(4'b0, 4'b0, 3, 1, 1, 0, 0);

        // Reversal: stop at floor 2 going up with only floor 0 pending
        step(4'b0, 4'b0010, 3, 1, 0, 0, 0);
        wait_at(3, 1, 1);
        wait_at(2, 0, 1);
        wait_at(1, 1, 1);
        step(4'b0, 4'b0, 1, 1, 1, 0, 0);
        step(4'b0, 4'b0100, 1, 1, 0, 0, 0);
        wait_at(1, 1, 1);
        wait_at(2, 1, 1);
        step(4'b0001, 4'b0, 2, 1, 0, 0, 0);
        step(4'b0, 4'b0, 2, 1, 1, 0, 0);
        wait_at(1, 0, 1);
        wait_at(0, 1, 1);
        step(4'b0, 4'b0, 0, 1, 1, 0, 0);

        // Emergency while travelling up: frozen, calls still latch
        step(4'b0, 4'b1000, 0, 1, 0, 0, 0);
        wait_at(0, 1, 1);
        wait_at(1, 0, 1);
        step(4'b0100, 4'b0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(4'b0, 4'b0, 1, 0, 0, 1, 0);
        wait_at(1, 0, 1);
        wait_at(2, 1, 1);
        step(4'b0, 4'b0, 2, 1, 1, 0, 0);
        wait_at(3, 1, 1);
        step(4'b0, 4'b0, 3, 1, 1, 0, 0);

        // Reset while travelling down with floors 0 and 1 pending
        step(4'b0, 4'b0011, 3, 1, 0, 0, 0);
        wait_at(3, 1, 1);
        wait_at(2, 0, 1);
        step(4'b0, 4'b0, 2, 0, 0, 0, 1);
        wait_at(2, 1, 1);

        // Random traffic
        piso_r = 2;
        for (int n = 0; n < 3000; n++) begin
            pet_r = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
            sel_r = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1 && piso_r < 3) piso_r++;
                else if (piso_r > 0) piso_r--;
            end
            en_r  = ($urandom_range(0, 9) < 7);
            srv_r = ($urandom_range(0, 4) == 0);
            emg_r = ($urandom_range(0, 29) == 0);
            rst_r = ($urandom_range(0, 199) == 0);
            step(pet_r, sel_r, piso_r, en_r, srv_r, emg_r, rst_r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/planificador_elevador.md
Name: planificador_elevador

Overview:
- Request scheduler for the 4-floor elevator system.
- Latches hall calls (peticion) and cab calls (seleccion) into a pending-request register.
- Runs a collective-SCAN policy: keep moving in the current direction while requests remain ahead, otherwise reverse.
- Issues move, direction and door-service commands to the motor/door datapath; sits between the button inputs and the motion controller.

Parameters:
- N_PISOS, 4, number of floors; width of the request vectors.
- W_PISO, 2, width of a floor index; equals clog2(N_PISOS).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous reset, active-high.
- peticion  in  N_PISOS  hall-call buttons; bit i is floor i+1; level or pulse.
- seleccion  in  N_PISOS  cab-call buttons; same encoding as peticion.
- piso_actual  in  W_PISO  last floor reached (0 = floor 1), decoded from the position sensor.
- en_piso  in  1  car is aligned at piso_actual.
- servido  in  1  one-cycle pulse from the door controller: the stop at piso_actual has completed.
- emergencia  in  1  emergency brake active.
- pendientes  out  N_PISOS  registered pending-request vector.
- mover  out  1  motor enable.
- direccion  out  1  1 = up, 0 = down.
- abrir_puerta  out  1  request to the door controller to service the current floor.
- objetivo  out  W_PISO  next floor to be served.
- objetivo_valido  out  1  objetivo is meaningful.

Behaviour:
- Reset (synchronous): pendientes=0, state=IDLE, direccion=1, mover=0, abrir_puerta=0, objetivo=0, objetivo_valido=0.
- Request register, every cycle:
  - pend <= (pend & ~clr) | peticion | seleccion.
  - clr = onehot(piso_actual) when servido=1, else 0.
  - A set and a clear of the same bit in the same cycle: set wins, and that floor is re-served later.
- Derived signals: arriba = any pend bit above piso_actual; abajo = any pend bit below; aqui = pend[piso_actual] & en_piso.
- FSM states: IDLE, SUBIR, BAJAR, PARADA.
  - IDLE: aqui -> PARADA; else arriba -> SUBIR (direccion<=1); else abajo -> BAJAR (direccion<=0). Up wins a tie.
  - SUBIR: aqui -> PARADA; else stay.
  - BAJAR: aqui -> PARADA; else stay.
  - PARADA: wait for servido. On servido, evaluate with pend already updated:
    - same-direction requests exist -> continue in that direction;
    - else opposite-direction requests exist -> reverse and update direccion;
    - else -> IDLE.
- Outputs are Moore, decoded from the registered state:
  - mover = (SUBIR | BAJAR) & ~emergencia.
  - abrir_puerta = PARADA.
- objetivo, combinational from registered pend/state/piso_actual:
  - SUBIR: nearest pending floor above piso_actual.
  - BAJAR: nearest pending floor below piso_actual.
  - PARADA: piso_actual.
  - IDLE: 0.
  - objetivo_valido = 0 in IDLE, 1 otherwise.
- Latency:
  - Button at cycle t -> pendientes bit set at t+1.
  - From IDLE, mover=1 at t+2.
  - Arrival (aqui) at cycle t -> mover=0 and abrir_puerta=1 at t+1.
- Emergency:
  - While emergencia=1 the state and direccion are frozen and mover=0.
  - Requests still latch, and servido still clears.
  - On release, operation resumes from the frozen state.
- Between floors (en_piso=0): no stop decision is taken; motion continues.
- servido outside PARADA: clears the bit only; no state change.
- Reset mid-travel: immediate return to the reset values; all pending requests are lost.

Decomposition:
- Shared package elevador_pkg:
  - N_PISOS and W_PISO constants.
  - FSM state encoding (IDLE=2'd0, SUBIR=2'd1, BAJAR=2'd2, PARADA=2'd3).
  - Direction constants (DIR_SUBIR=1, DIR_BAJAR=0).
- Sub-module buscar_piso: combinational nearest-set-bit search above/below a floor index.
  - Outputs: arriba, abajo, piso_arriba, piso_abajo.
  - Instantiated once.

Test Plan:
- Reset, piso_actual=0, en_piso=1; pulse peticion=0001 -> PARADA, abrir_puerta=1 two cycles later, mover stays 0; servido pulse -> pendientes=0000, state IDLE.
- Idle at floor 0; seleccion=1000 for one cycle -> pendientes=1000, mover=1 and direccion=1 at t+2, objetivo=3; set piso_actual=3, en_piso=1 -> mover=0, abrir_puerta=1.
- Moving up from floor 0 with pend=1010: set piso_actual=1, en_piso=1 -> stop at floor 1; servido -> resumes SUBIR, objetivo=3.
- At floor 2 going up with pend=0001 only; servido -> direccion=0, BAJAR, objetivo=0.
- SUBIR toward floor 3; assert emergencia for 4 cycles -> mover=0, state and pendientes held, new peticion=0100 still latched; release -> mover=1 on the next cycle.
- Assert rst during BAJAR with pend=0011 -> next cycle: pendientes=0, mover=0, direccion=1, objetivo_valido=0.
